spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_slave_if.sv | 11 +
 rtl/spi_sync.sv | 26 ++
 rtl/spi_slave.sv | 176 +++++++++++++++++
 tb/tb_spi_slave.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: default frame geometry and the frame FSM state encoding,
// common to the SPI slave and the SPI master.
`timescale 1ns/1ps
package spi_pkg;

  localparam int SPI_CMD_WIDTH  = 12;
  localparam int SPI_DATA_WIDTH = 8;
  localparam int SPI_ADDR_WIDTH = 3;
  // Frame layout, MSB first: {rw, addr, data}; rw = 1 means write.
  localparam int SPI_RW_BIT     = SPI_CMD_WIDTH - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    DONE  = 3'd4
  } spi_state_t;

endpackage

// File: rtl/spi_slave_if.sv
// SPI bus pins: the master drives sclk, cs and mosi; the slave drives miso.
`timescale 1ns/1ps
interface spi_slave_if;
  logic sclk;
  logic cs;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs, output mosi, input miso);
  modport slave  (input sclk, input cs, input mosi, output miso);
endinterface

// File: rtl/spi_sync.sv
// Multi-stage single-bit synchronizer with a selectable reset value.
`timescale 1ns/1ps
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {STAGES{RST_VAL}};
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave fronting a small register file. Every SPI pin is
// oversampled on clk; frames are {rw, addr, data}, MSB first.
`timescale 1ns/1ps
module spi_slave
  import spi_pkg::*;
#(
  parameter int CMD_WIDTH  = SPI_CMD_WIDTH,
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int ADDR_WIDTH = SPI_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_slave_if.slave            spi,
  output logic                  wr_vld,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_vld,
  output logic                  frame_err,
  input  logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_data
);

  localparam int CNT_W = $clog2(CMD_WIDTH + 1);
  localparam int REGS  = 1 << ADDR_WIDTH;
  // Counter value seen on the last header rise and on the last frame rise.
  localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(CMD_WIDTH - 1);

  spi_state_t state_reg, state_next;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d;
  logic bit_rise, bit_fall, cs_fall, cs_rise, frame_active;
  logic abort, hdr_done, last_rise;
  logic rw_bit;
  logic [ADDR_WIDTH-1:0] hdr_addr;
  logic [CNT_W-1:0]      cnt_reg;
  // The R/W bit falls off the top once the full frame is in, so one bit less suffices.
  logic [CMD_WIDTH-2:0]  rx_reg, rx_shift;
  logic [DATA_WIDTH-1:0] tx_reg;
  logic                  miso_reg;
  logic                  commit_reg;
  logic [ADDR_WIDTH-1:0] commit_addr;
  logic [DATA_WIDTH-1:0] commit_data;
  logic [DATA_WIDTH-1:0] regs [REGS];

  spi_sync #(.STAGES(2), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(spi.sclk), .q(sclk_s));
  spi_sync #(.STAGES(2), .RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(spi.cs),   .q(cs_s));
  spi_sync #(.STAGES(2), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(spi.mosi), .q(mosi_s));

  // Delayed copies of the synchronized pins for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  // sclk edges only count while the slave is selected.
  assign bit_rise     = sclk_s & ~sclk_d & ~cs_s;
  assign bit_fall     = ~sclk_s & sclk_d & ~cs_s;
  assign cs_fall      = ~cs_s & cs_d;
  assign cs_rise      = cs_s & ~cs_d;
  assign frame_active = (state_reg == CMD) || (state_reg == WDATA) || (state_reg == RDATA);

  // Receive register as it will look after the current rise; on the last header
  // rise its low bits hold {rw, addr}.
  assign rx_shift    = {rx_reg[CMD_WIDTH-3:0], mosi_s};
  assign rw_bit      = rx_shift[ADDR_WIDTH];
  assign hdr_addr    = rx_shift[ADDR_WIDTH-1:0];
  assign commit_addr = rx_reg[CMD_WIDTH-2 -: ADDR_WIDTH];
  assign commit_data = rx_reg[DATA_WIDTH-1:0];

  // Frame FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Frame FSM next state and per-cycle event strobes.
  always_comb begin
    state_next = state_reg;
    abort      = 1'b0;
    hdr_done   = 1'b0;
    last_rise  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cs_fall) state_next = CMD;
      end
      CMD: begin
        if (cs_rise) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (bit_rise && cnt_reg == HDR_LAST) begin
          hdr_done   = 1'b1;
          state_next = rw_bit ? WDATA : RDATA;
        end
      end
      WDATA, RDATA: begin
        if (cs_rise) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (bit_rise && cnt_reg == FRAME_LAST) begin
          last_rise  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (cs_rise) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift registers, bit counter and host-side strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      rx_reg     <= '0;
      tx_reg     <= '0;
      miso_reg   <= 1'b0;
      commit_reg <= 1'b0;
      wr_vld     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rd_vld     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      wr_vld     <= 1'b0;
      rd_vld     <= last_rise && (state_reg == RDATA);
      frame_err  <= abort;
      commit_reg <= last_rise && (state_reg == WDATA);

      if (state_reg == IDLE) begin
        cnt_reg <= '0;
      end else if (frame_active && bit_rise) begin
        cnt_reg <= cnt_reg + 1'b1;
        rx_reg  <= rx_shift;
      end

      if (hdr_done && !rw_bit) begin
        tx_reg <= regs[hdr_addr];
      end else if (state_reg == RDATA && bit_fall) begin
        tx_reg <= {tx_reg[DATA_WIDTH-2:0], 1'b0};
      end

      if (state_reg != RDATA) begin
        miso_reg <= 1'b0;
      end else if (bit_fall) begin
        miso_reg <= tx_reg[DATA_WIDTH-1];
      end

      if (commit_reg) begin
        wr_vld  <= 1'b1;
        wr_addr <= commit_addr;
        wr_data <= commit_data;
      end
    end
  end

  // Register file, written one clk after the last rise of a write frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else if (commit_reg) begin
      regs[commit_addr] <= commit_data;
    end
  end

  assign spi.miso = (state_reg == RDATA) ? miso_reg : 1'b0;
  assign reg_data = regs[reg_addr];

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: write, read-back, abort, over-clocking,
// mid-frame reset and back-to-back frames at minimum sclk timing.
`timescale 1ns/1ps
module tb_spi_slave;

  localparam int HALF = 4;  // sclk half-period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_vld, rd_vld, frame_err;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] reg_addr = 3'd0;
  logic [7:0] reg_data;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int err_pulses = 0;
  int wr_before, rd_before, err_before;
  logic [11:0] miso_bits;
  logic [7:0]  rd_byte;

  spi_slave_if spi_bus ();

  spi_slave dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi(spi_bus),
    .wr_vld(wr_vld),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_vld(rd_vld),
    .frame_err(frame_err),
    .reg_addr(reg_addr),
    .reg_data(reg_data)
  );

  always #5 clk = ~clk;

  // Count strobe cycles away from the active edge.
  always @(negedge clk) begin
    if (wr_vld)    wr_pulses++;
    if (rd_vld)    rd_pulses++;
    if (frame_err) err_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One frame of nclk sclk cycles; frame is {rw, addr[2:0], data[7:0]}.
  // miso is recorded just before each of the first 12 rises.
  task automatic spi_frame(input logic [11:0] frame, input int nclk, input bit end_cs, input int gap);
    spi_bus.cs = 1'b0;
    for (int i = 0; i < nclk; i++) begin
      spi_bus.mosi = (i < 12) ? frame[11-i] : 1'b0;
      repeat (HALF) @(negedge clk);
      if (i < 12) miso_bits[i] = spi_bus.miso;
      spi_bus.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_bus.sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    if (end_cs) begin
      spi_bus.cs = 1'b1;
      repeat (gap) @(negedge clk);
    end
    $display("frame 0x%03h nclk=%0d cs_end=%0d wr=%0d rd=%0d err=%0d",
             frame, nclk, end_cs, wr_pulses, rd_pulses, err_pulses);
  endtask

  task automatic peek(input logic [2:0] a);
    @(negedge clk);
    reg_addr = a;
    #1;
  endtask

  initial begin
    spi_bus.sclk = 1'b0;
    spi_bus.cs   = 1'b1;
    spi_bus.mosi = 1'b0;
    miso_bits    = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_wr_vld", wr_vld, 0);
    check("rst_rd_vld", rd_vld, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_miso", spi_bus.miso, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    peek(3'd1);
    check("rst_reg1", reg_data, 8'h00);

    // Write addr 1 <= 0xA5
    wr_before = wr_pulses;
    spi_frame(12'h9A5, 12, 1, 10);
    check("wr_pulse", wr_pulses - wr_before, 1);
    check("wr_addr", wr_addr, 3'd1);
    check("wr_data", wr_data, 8'hA5);
    peek(3'd1);
    check("wr_reg1", reg_data, 8'hA5);
    check("wr_no_err", err_pulses, 0);

    // Read back addr 1
    wr_before = wr_pulses;
    rd_before = rd_pulses;
    spi_frame(12'h100, 12, 1, 10);
    for (int i = 0; i < 8; i++) rd_byte[7-i] = miso_bits[4+i];
    check("rd_miso_byte", rd_byte, 8'hA5);
    check("rd_miso_hdr", miso_bits[3:0], 4'h0);
    check("rd_pulse", rd_pulses - rd_before, 1);
    check("rd_no_wr", wr_pulses - wr_before, 0);
    check("rd_miso_idle", spi_bus.miso, 0);

    // Abort: write addr 7 <= 0xFF cut off after 6 sclk
    wr_before  = wr_pulses;
    err_before = err_pulses;
    spi_frame(12'hFFF, 6, 1, 10);
    check("abort_err", err_pulses - err_before, 1);
    check("abort_no_wr", wr_pulses - wr_before, 0);
    peek(3'd7);
    check("abort_reg7", reg_data, 8'h00);

    // Over-clocking: write addr 2 <= 0xC3 with 16 sclk
    wr_before  = wr_pulses;
    err_before = err_pulses;
    spi_frame(12'hAC3, 16, 1, 10);
    check("ovr_wr_pulse", wr_pulses - wr_before, 1);
    check("ovr_wr_addr", wr_addr, 3'd2);
    check("ovr_wr_data", wr_data, 8'hC3);
    check("ovr_no_err", err_pulses - err_before, 0);
    peek(3'd2);
    check("ovr_reg2", reg_data, 8'hC3);

    // Reset mid-frame, released with cs still low
    wr_before = wr_pulses;
    spi_frame(12'hFFF, 5, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_wr_vld", wr_vld, 0);
    peek(3'd1);
    check("mid_rst_reg1", reg_data, 8'h00);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    spi_frame(12'hFFF, 7, 1, 10);
    check("mid_rst_no_wr", wr_pulses - wr_before, 0);
    peek(3'd7);
    check("mid_rst_reg7", reg_data, 8'h00);
    spi_frame(12'hB11, 12, 1, 10);
    check("post_rst_wr_pulse", wr_pulses - wr_before, 1);
    check("post_rst_wr_addr", wr_addr, 3'd3);
    check("post_rst_wr_data", wr_data, 8'h11);
    peek(3'd3);
    check("post_rst_reg3", reg_data, 8'h11);

    // Back-to-back frames at minimum timing, cs high for 4 clk between frames
    wr_before  = wr_pulses;
    err_before = err_pulses;
    spi_frame(12'hC3C, 12, 1, 4);
    spi_frame(12'hD5A, 12, 1, 4);
    spi_frame(12'hE96, 12, 1, 10);
    check("b2b_wr_pulses", wr_pulses - wr_before, 3);
    check("b2b_no_err", err_pulses - err_before, 0);
    check("b2b_last_addr", wr_addr, 3'd6);
    check("b2b_last_data", wr_data, 8'h96);
    peek(3'd4);
    check("b2b_reg4", reg_data, 8'h3C);
    peek(3'd5);
    check("b2b_reg5", reg_data, 8'h5A);
    peek(3'd6);
    check("b2b_reg6", reg_data, 8'h96);
    peek(3'd3);
    check("b2b_reg3_kept", reg_data, 8'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
